count_dia: RTL and testbench

COUNT_DIA -- requirements
Module: count_dia

---
 rtl/count_dia_pkg.sv | 28 ++
 rtl/count_dia_dias_mes.sv | 24 ++
 rtl/count_dia.sv | 100 ++++++++++
 tb/tb_count_dia.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_dia_pkg.sv
// Shared calendar constants for the day/month counters.
// Month codes, day limits and the previous-month helper.
package count_dia_pkg;

  localparam logic [3:0] ENE = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] ABR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AGO = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DIC = 4'd12;

  localparam logic [4:0] DIAS28 = 5'd28;
  localparam logic [4:0] DIAS29 = 5'd29;
  localparam logic [4:0] DIAS30 = 5'd30;
  localparam logic [4:0] DIAS31 = 5'd31;

  // January (and the unused code 0) wrap back to December.
  function automatic logic [3:0] mesPrev(input logic [3:0] m);
    return (m <= ENE) ? DIC : m - 4'd1;
  endfunction

endpackage

// File: rtl/count_dia_dias_mes.sv
// Days-in-month lookup.
// Out-of-range month codes report 31 days.
module dias_mes
  import count_dia_pkg::*;
#(
  parameter int LEAP_EN = 1
) (
  input  logic [3:0] mes,
  input  logic       leap,
  output logic [4:0] maxDia
);

  // Month length from the calendar table.
  always_comb begin
    maxDia = DIAS31;
    case (mes)
      ABR, JUN, SEP, NOV: maxDia = DIAS30;
      FEB:
        maxDia = (leap && (LEAP_EN != 0)) ? DIAS29 : DIAS28;
      default: maxDia = DIAS31;
    endcase
  end

endmodule

// File: rtl/count_dia.sv
// Day-of-month counter with BCD outputs.
// Carry/borrow pulses step the month counter.
module count_dia
  import count_dia_pkg::*;
#(
  parameter int LEAP_EN = 1
) (
  input  logic       clkM,
  input  logic       resetM,
  input  logic       enD,
  input  logic       upD,
  input  logic       downD,
  input  logic       ldD,
  input  logic [4:0] dinD,
  input  logic [3:0] mesD,
  input  logic       leapD,
  output logic [4:0] qD,
  output logic [1:0] decD,
  output logic [3:0] uniD,
  output logic       carryD,
  output logic       borrowD
);

  logic [4:0] maxCur;
  logic [4:0] maxPrev;
  logic [3:0] mesAnt;
  logic [4:0] uniTmp;
  logic       goUp;
  logic       goDown;

  assign mesAnt = mesPrev(mesD);
  assign goUp   = enD && upD && !downD;
  assign goDown = enD && downD && !upD;

  dias_mes #(.LEAP_EN(LEAP_EN)) uMaxCur (
    .mes    (mesD),
    .leap   (leapD),
    .maxDia (maxCur)
  );

  dias_mes #(.LEAP_EN(LEAP_EN)) uMaxPrev (
    .mes    (mesAnt),
    .leap   (leapD),
    .maxDia (maxPrev)
  );

  // Day state: load, then count, then clamp, else hold.
  always_ff @(posedge clkM or posedge resetM) begin
    if (resetM) begin
      qD      <= 5'd1;
      carryD  <= 1'b0;
      borrowD <= 1'b0;
    end else begin
      carryD  <= 1'b0;
      borrowD <= 1'b0;
      if (ldD) begin
        if (dinD == 5'd0)
          qD <= 5'd1;
        else if (dinD > maxCur)
          qD <= maxCur;
        else
          qD <= dinD;
      end else if (goUp) begin
        if (qD >= maxCur) begin
          qD     <= 5'd1;
          carryD <= 1'b1;
        end else begin
          qD <= qD + 5'd1;
        end
      end else if (goDown) begin
        if (qD <= 5'd1) begin
          qD      <= maxPrev;
          borrowD <= 1'b1;
        end else begin
          qD <= qD - 5'd1;
        end
      end else if (qD > maxCur) begin
        qD <= maxCur;
      end
    end
  end

  // BCD split by range compare instead of a divider.
  always_comb begin
    decD   = 2'd0;
    uniTmp = qD;
    if (qD >= 5'd30) begin
      decD   = 2'd3;
      uniTmp = qD - 5'd30;
    end else if (qD >= 5'd20) begin
      decD   = 2'd2;
      uniTmp = qD - 5'd20;
    end else if (qD >= 5'd10) begin
      decD   = 2'd1;
      uniTmp = qD - 5'd10;
    end
    uniD = uniTmp[3:0];
  end

endmodule

// File: tb/tb_count_dia.sv
// Self-checking bench for count_dia.
// Directed calendar cases plus random traffic against a day model.
module tb_count_dia;

  logic       clkM = 1'b0;
  logic       resetM;
  logic       enD;
  logic       upD;
  logic       downD;
  logic       ldD;
  logic [4:0] dinD;
  logic [3:0] mesD;
  logic       leapD;
  logic [4:0] qD;
  logic [1:0] decD;
  logic [3:0] uniD;
  logic       carryD;
  logic       borrowD;

  int errors = 0;
  int checks = 0;

  int eq = 1;
  int ec = 0;
  int eb = 0;

  int dim [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  count_dia #(.LEAP_EN(1)) dut (
    .clkM    (clkM),
    .resetM  (resetM),
    .enD     (enD),
    .upD     (upD),
    .downD   (downD),
    .ldD     (ldD),
    .dinD    (dinD),
    .mesD    (mesD),
    .leapD   (leapD),
    .qD      (qD),
    .decD    (decD),
    .uniD    (uniD),
    .carryD  (carryD),
    .borrowD (borrowD)
  );

  always #5 clkM = ~clkM;

  function automatic int monthLen(input int m, input int lp);
    if (m < 1 || m > 12) return 31;
    if (m == 2 && lp != 0) return 29;
    return dim[m-1];
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".q"}, int'(qD), eq);
    chk({tag, ".carry"}, int'(carryD), ec);
    chk({tag, ".borrow"}, int'(borrowD), eb);
    chk({tag, ".dec"}, int'(decD), eq / 10);
    chk({tag, ".uni"}, int'(uniD), eq % 10);
  endtask

  // Advance one edge and move the model by the calendar rules.
  task automatic step(input string tag);
    int mx;
    int pm;
    int m;
    int d;
    mx = monthLen(int'(mesD), int'(leapD));
    m  = int'(mesD);
    d  = int'(dinD);
    ec = 0;
    eb = 0;
    @(posedge clkM);
    #1;
    if (ldD) begin
      eq = (d == 0) ? 1 : ((d > mx) ? mx : d);
    end else if (enD && upD && !downD) begin
      if (eq >= mx) begin
        eq = 1;
        ec = 1;
      end else begin
        eq = eq + 1;
      end
    end else if (enD && downD && !upD) begin
      if (eq == 1) begin
        pm = (m <= 1) ? 12 : m - 1;
        eq = monthLen(pm, int'(leapD));
        eb = 1;
      end else begin
        eq = eq - 1;
      end
    end else if (eq > mx) begin
      eq = mx;
    end
    checkAll(tag);
  endtask

  task automatic idle();
    enD   = 1'b0;
    upD   = 1'b0;
    downD = 1'b0;
    ldD   = 1'b0;
  endtask

  task automatic load(input int v);
    idle();
    ldD  = 1'b1;
    dinD = 5'(v);
    step("load");
    ldD  = 1'b0;
  endtask

  initial begin
    int ncar;
    int mon;
    resetM = 1'b1;
    idle();
    dinD  = 5'd0;
    mesD  = 4'd1;
    leapD = 1'b0;
    #1;
    eq = 1; ec = 0; eb = 0;
    checkAll("reset");
    repeat (2) @(posedge clkM);
    @(negedge clkM);
    resetM = 1'b0;

    // Load saturation and zero handling.
    load(0);
    load(25);
    mesD = 4'd2;
    leapD = 1'b0;
    load(31);

    // End of January wraps with a single carry.
    mesD = 4'd1;
    load(31);
    enD = 1'b1; upD = 1'b1;
    step("janWrap");
    idle();
    step("janAfter");

    // Borrow into February, leap and common year.
    mesD = 4'd3;
    leapD = 1'b1;
    load(1);
    enD = 1'b1; downD = 1'b1;
    step("marLeap");
    idle();
    step("marLeapAfter");
    leapD = 1'b0;
    load(1);
    enD = 1'b1; downD = 1'b1;
    step("marCommon");
    idle();

    // Month change forces a clamp.
    mesD = 4'd1;
    load(31);
    mesD = 4'd4;
    step("clampApr");

    // Conflicting up/down holds.
    enD = 1'b1; upD = 1'b1; downD = 1'b1;
    repeat (5) step("bothHeld");
    idle();

    // Async reset mid-cycle drops a pending carry.
    mesD = 4'd1;
    load(31);
    enD = 1'b1; upD = 1'b1;
    step("preReset");
    idle();
    #2;
    resetM = 1'b1;
    #1;
    eq = 1; ec = 0; eb = 0;
    checkAll("asyncReset");
    @(negedge clkM);
    resetM = 1'b0;

    // A full common year with the carry feeding a month counter.
    mon = 1;
    mesD = 4'd1;
    leapD = 1'b0;
    load(1);
    ncar = 0;
    enD = 1'b1; upD = 1'b1;
    for (int i = 0; i < 365; i++) begin
      step("year");
      if (carryD) begin
        ncar++;
        mon = (mon == 12) ? 1 : mon + 1;
        mesD = 4'(mon);
      end
    end
    chk("yearCarries", ncar, 12);
    chk("yearEndQ", int'(qD), 1);
    idle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      enD   = 1'($urandom_range(0, 3) != 0);
      upD   = 1'($urandom);
      downD = 1'($urandom);
      ldD   = 1'($urandom_range(0, 9) == 0);
      dinD  = 5'($urandom);
      if ($urandom_range(0, 7) == 0)
        mesD = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0)
        leapD = 1'($urandom);
      step("rand");
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
